// File: rtl/mem_fill_if.sv
// Request/response and backing-memory signal bundle for mem_fill_responder.
// The slave modport is the responder's view; the master modport is the pipeline/memory side.
interface mem_fill_if;
    logic        MemoryRequest;
    logic        RequestWrite;
    logic [15:0] MemoryAddressIn;
    logic [15:0] MemoryDataIn;
    logic [15:0] MemData;
    logic [15:0] MemAddress;
    logic        MemCacheWriteEnable;
    logic        MemStall;
    logic        BackEnable;
    logic        BackWrite;
    logic [15:0] BackAddress;
    logic [15:0] BackDataOut;
    logic [15:0] BackDataIn;

    modport slave (
        input  MemoryRequest, RequestWrite, MemoryAddressIn, MemoryDataIn, BackDataIn,
        output MemData, MemAddress, MemCacheWriteEnable, MemStall,
               BackEnable, BackWrite, BackAddress, BackDataOut
    );

    modport master (
        output MemoryRequest, RequestWrite, MemoryAddressIn, MemoryDataIn, BackDataIn,
        input  MemData, MemAddress, MemCacheWriteEnable, MemStall,
               BackEnable, BackWrite, BackAddress, BackDataOut
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Cache block-fill / word-write responder in front of a fixed-latency backing memory.
// Optional macro FILL_CRITICAL_FIRST_EN starts a fill at the requested word and wraps.
module mem_fill_responder #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_fill_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t      state;
    logic [11:0] base_r;
    logic [2:0]  idx;
    logic [3:0]  issue_cnt;
    logic [3:0]  ret_cnt;
    logic [3:0]  wait_cnt;
    logic [2:0]  start_idx;

    logic        vld_p  [LATENCY];
    logic [15:0] addr_p [LATENCY];
    logic [15:0] data_hold;
    logic [15:0] addr_hold;
    logic        pop;

`ifdef FILL_CRITICAL_FIRST_EN
    assign start_idx = bus.MemoryAddressIn[3:1];
`else
    assign start_idx = 3'd0;
`endif

    assign pop = vld_p[LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            base_r          <= '0;
            idx             <= '0;
            issue_cnt       <= '0;
            ret_cnt         <= '0;
            wait_cnt        <= '0;
            bus.BackEnable  <= 1'b0;
            bus.BackWrite   <= 1'b0;
            bus.BackAddress <= '0;
            bus.BackDataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MemoryRequest) begin
                        bus.BackEnable <= 1'b1;
                        if (bus.RequestWrite) begin
                            state           <= WRITE;
                            bus.BackWrite   <= 1'b1;
                            bus.BackAddress <= bus.MemoryAddressIn & 16'hFFFE;
                            bus.BackDataOut <= bus.MemoryDataIn;
                            wait_cnt        <= '0;
                        end else begin
                            state           <= FILL;
                            bus.BackWrite   <= 1'b0;
                            base_r          <= bus.MemoryAddressIn[15:4];
                            bus.BackAddress <= {bus.MemoryAddressIn[15:4], start_idx, 1'b0};
                            idx             <= start_idx + 3'd1;
                            issue_cnt       <= 4'd1;
                            ret_cnt         <= '0;
                        end
                    end
                end
                FILL: begin
                    // Word index wraps within the block, so the address never leaves it.
                    if (issue_cnt < 4'(BLOCK_WORDS)) begin
                        bus.BackEnable  <= 1'b1;
                        bus.BackAddress <= {base_r, idx, 1'b0};
                        idx             <= idx + 3'd1;
                        issue_cnt       <= issue_cnt + 4'd1;
                    end else begin
                        bus.BackEnable  <= 1'b0;
                    end
                    if (pop) begin
                        if (ret_cnt == 4'(BLOCK_WORDS - 1)) begin
                            state   <= IDLE;
                            ret_cnt <= '0;
                        end else begin
                            ret_cnt <= ret_cnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    bus.BackEnable <= 1'b0;
                    bus.BackWrite  <= 1'b0;
                    if (wait_cnt == 4'(LATENCY)) state <= IDLE;
                    else wait_cnt <= wait_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency tracker: valid bit per issued read, popped as its data arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
            data_hold <= '0;
            addr_hold <= '0;
        end else begin
            vld_p[0] <= bus.BackEnable & ~bus.BackWrite;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
            if (pop) begin
                data_hold <= bus.BackDataIn;
                addr_hold <= addr_p[LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_p[0] <= bus.BackAddress;
        for (int i = 1; i < LATENCY; i++) addr_p[i] <= addr_p[i-1];
    end

    assign bus.MemCacheWriteEnable = pop;
    assign bus.MemData    = pop ? bus.BackDataIn       : data_hold;
    assign bus.MemAddress = pop ? addr_p[LATENCY-1]    : addr_hold;
    assign bus.MemStall   = (state != IDLE) | ((state == IDLE) & bus.MemoryRequest);

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: reset, fills, write, mid-fill reset, back-to-back.
// Backing memory returns (address ^ 16'hA5A5) exactly four cycles after each read strobe.
module tb_mem_fill_responder;

    localparam int L = 4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    mem_fill_if bus ();

    mem_fill_responder #(.LATENCY(L), .BLOCK_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing-memory model: independent of responder reset, as real memory would be.
    logic        bvld [L];
    logic [15:0] badr [L];
    initial for (int i = 0; i < L; i++) begin bvld[i] = 1'b0; badr[i] = '0; end
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            bvld[i] <= bvld[i-1];
            badr[i] <= badr[i-1];
        end
        bvld[0] <= bus.BackEnable & ~bus.BackWrite;
        badr[0] <= bus.BackAddress;
    end
    assign bus.BackDataIn = bvld[L-1] ? (badr[L-1] ^ 16'hA5A5) : 16'h0000;

    function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef FILL_CRITICAL_FIRST_EN
        return a[3:1];
`else
        return 3'd0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        compared++;
        if ({bus.BackEnable, bus.BackWrite, bus.BackAddress, bus.BackDataOut,
             bus.MemCacheWriteEnable, bus.MemData, bus.MemAddress, bus.MemStall} !== '0) begin
            mismatched++;
            $display("FAIL %s outputs got BE=%b BW=%b BA=%h BD=%h WE=%b MD=%h MA=%h ST=%b want all 0",
                     tag, bus.BackEnable, bus.BackWrite, bus.BackAddress, bus.BackDataOut,
                     bus.MemCacheWriteEnable, bus.MemData, bus.MemAddress, bus.MemStall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.MemoryRequest = 1'b0; bus.RequestWrite = 1'b0;
        bus.MemoryAddressIn = '0; bus.MemoryDataIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    // Fill at addr; if hold_next, request stays high with next_addr so it is taken on return to IDLE.
    // skip_drive0 means the acceptance cycle is already in progress (back-to-back).
    task automatic test_fill(input logic [15:0] addr, input bit hold_next,
                             input logic [15:0] next_addr, input bit skip_drive0, input string tag);
        logic [15:0] base, ea;
        logic [2:0]  st, k;
        logic        ebe, ewe, est;
        base = addr & 16'hFFF0;
        st   = start_of(addr);
        if (!skip_drive0) begin
            @(posedge clk); #1;
            bus.MemoryRequest = 1'b1; bus.RequestWrite = 1'b0; bus.MemoryAddressIn = addr;
            @(negedge clk);
            compared++;
            if (bus.MemStall !== 1'b1) begin
                mismatched++;
                $display("FAIL %s stall_accept got %b want 1", tag, bus.MemStall);
            end
        end
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            bus.MemoryRequest   = hold_next;
            bus.MemoryAddressIn = hold_next ? next_addr : 16'h0BAD;
            @(negedge clk);
            ebe = (c <= 8);
            compared++;
            if (bus.BackEnable !== ebe) begin
                mismatched++;
                $display("FAIL %s c=%0d BackEnable got %b want %b", tag, c, bus.BackEnable, ebe);
            end
            if (ebe) begin
                k  = st + 3'(c - 1);
                ea = base | {12'h000, k, 1'b0};
                compared++;
                if (bus.BackAddress !== ea || bus.BackWrite !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s c=%0d BackAddress got %h/w%b want %h/w0", tag, c,
                             bus.BackAddress, bus.BackWrite, ea);
                end
            end
            ewe = (c >= 1 + L) && (c <= 8 + L);
            compared++;
            if (bus.MemCacheWriteEnable !== ewe) begin
                mismatched++;
                $display("FAIL %s c=%0d MemCacheWriteEnable got %b want %b", tag, c,
                         bus.MemCacheWriteEnable, ewe);
            end
            if (ewe) begin
                k  = st + 3'(c - 1 - L);
                ea = base | {12'h000, k, 1'b0};
                compared++;
                if (bus.MemAddress !== ea || bus.MemData !== (ea ^ 16'hA5A5)) begin
                    mismatched++;
                    $display("FAIL %s c=%0d return got %h:%h want %h:%h", tag, c,
                             bus.MemAddress, bus.MemData, ea, ea ^ 16'hA5A5);
                end
            end
            est = (c <= 8 + L) || hold_next;
            compared++;
            if (bus.MemStall !== est) begin
                mismatched++;
                $display("FAIL %s c=%0d MemStall got %b want %b", tag, c, bus.MemStall, est);
            end
        end
    endtask

    task automatic test_write();
        int strobes;
        logic ebe, est;
        strobes = 0;
        @(posedge clk); #1;
        bus.MemoryRequest = 1'b1; bus.RequestWrite = 1'b1;
        bus.MemoryAddressIn = 16'h2001; bus.MemoryDataIn = 16'hBEEF;
        @(negedge clk);
        compared++;
        if (bus.MemStall !== 1'b1) begin
            mismatched++;
            $display("FAIL write stall_accept got %b want 1", bus.MemStall);
        end
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            bus.MemoryRequest = 1'b0; bus.RequestWrite = 1'b0;
            bus.MemoryAddressIn = 16'h0BAD; bus.MemoryDataIn = 16'h1111;
            @(negedge clk);
            ebe = (c == 1);
            est = (c <= 1 + L);
            if (bus.BackEnable) strobes++;
            compared++;
            if (bus.BackEnable !== ebe) begin
                mismatched++;
                $display("FAIL write c=%0d BackEnable got %b want %b", c, bus.BackEnable, ebe);
            end
            if (ebe) begin
                compared++;
                if (bus.BackWrite !== 1'b1 || bus.BackAddress !== 16'h2000 || bus.BackDataOut !== 16'hBEEF) begin
                    mismatched++;
                    $display("FAIL write strobe got w%b %h:%h want w1 2000:beef",
                             bus.BackWrite, bus.BackAddress, bus.BackDataOut);
                end
            end
            compared++;
            if (bus.MemCacheWriteEnable !== 1'b0) begin
                mismatched++;
                $display("FAIL write c=%0d MemCacheWriteEnable got 1 want 0", c);
            end
            compared++;
            if (bus.MemStall !== est) begin
                mismatched++;
                $display("FAIL write c=%0d MemStall got %b want %b", c, bus.MemStall, est);
            end
        end
        compared++;
        if (strobes !== 1) begin
            mismatched++;
            $display("FAIL write strobe_count got %0d want 1", strobes);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] third;
        third = 16'h4000 | {12'h000, start_of(16'h4000) + 3'd2, 1'b0};
        @(posedge clk); #1;
        bus.MemoryRequest = 1'b1; bus.RequestWrite = 1'b0; bus.MemoryAddressIn = 16'h4000;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            bus.MemoryRequest = 1'b0;
        end
        @(negedge clk);
        compared++;
        if (bus.MemCacheWriteEnable !== 1'b1 || bus.MemAddress !== third) begin
            mismatched++;
            $display("FAIL rst_mid third_return got %b:%h want 1:%h",
                     bus.MemCacheWriteEnable, bus.MemAddress, third);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid_after");
        for (int c = 10; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            compared++;
            if (bus.MemCacheWriteEnable !== 1'b0 || bus.MemStall !== 1'b0) begin
                mismatched++;
                $display("FAIL rst_mid c=%0d WE/stall got %b/%b want 0/0", c,
                         bus.MemCacheWriteEnable, bus.MemStall);
            end
        end
        test_fill(16'h5006, 1'b0, 16'h0000, 1'b0, "after_rst_fill");
    endtask

    task automatic test_back_to_back();
        test_fill(16'h1000, 1'b1, 16'h2008, 1'b0, "b2b_first");
        test_fill(16'h2008, 1'b0, 16'h0000, 1'b1, "b2b_second");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_fill(16'h1234, 1'b0, 16'h0000, 1'b0, "fill_1234");
        test_fill(16'h123C, 1'b0, 16'h0000, 1'b0, "fill_123C");
        test_fill(16'hFFF8, 1'b0, 16'h0000, 1'b0, "fill_FFF8");
        test_write();
        test_reset_mid_fill();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
